// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU-pin and response bundle for alu_share_arbiter.
// ALU_ARB_LOCK_EN adds the per-requester i_req_lock bits.
interface alu_share_arbiter_if;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [63:0] i_req_op_a;
  logic [63:0] i_req_op_b;
  logic [7:0]  i_req_alu_op;
  logic [1:0]  i_req_jalr;
`ifdef ALU_ARB_LOCK_EN
  logic [1:0]  i_req_lock;
`endif
  logic [31:0] o_alu_op_a;
  logic [31:0] o_alu_op_b;
  logic [3:0]  o_alu_op;
  logic        o_alu_jalr;
  logic [31:0] i_alu_data;
  logic        o_rsp_valid;
  logic        o_rsp_id;
  logic [31:0] o_rsp_data;
  logic        i_rsp_ready;

  modport slave (
`ifdef ALU_ARB_LOCK_EN
    input  i_req_lock,
`endif
    input  i_req_valid, i_req_op_a, i_req_op_b, i_req_alu_op, i_req_jalr,
    output o_req_ready,
    output o_alu_op_a, o_alu_op_b, o_alu_op, o_alu_jalr,
    input  i_alu_data,
    output o_rsp_valid, o_rsp_id, o_rsp_data,
    input  i_rsp_ready
  );

  modport master (
`ifdef ALU_ARB_LOCK_EN
    output i_req_lock,
`endif
    output i_req_valid, i_req_op_a, i_req_op_b, i_req_alu_op, i_req_jalr,
    input  o_req_ready,
    input  o_alu_op_a, o_alu_op_b, o_alu_op, o_alu_jalr,
    output i_alu_data,
    input  o_rsp_valid, o_rsp_id, o_rsp_data,
    output i_rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, results queued with id.
// Optional ALU_ARB_LOCK_EN: a requester may lock the grant across consecutive handshakes.
module alu_share_arbiter #(
  parameter int unsigned DEPTH     = 2,
  parameter bit          PRIO_INIT = 1'b0
) (
  input logic               i_clk,
  input logic               i_reset,
  alu_share_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [32:0]   r_mem [DEPTH];
  logic [32:0]   r_head;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_prio;
  logic          r_run;
`ifdef ALU_ARB_LOCK_EN
  logic          r_lock;
  logic          r_lock_id;
`endif

  logic          w_rsp_valid;
  logic          w_space;
  logic          w_ok;
  logic          w_rr_win;
  logic          w_rr_grant;
  logic          w_win;
  logic          w_grant;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rd_next;

  assign w_rsp_valid = (r_count != '0);
  assign w_pop       = w_rsp_valid & bus.i_rsp_ready;
  assign w_space     = (r_count < CW'(DEPTH)) | w_pop;
  assign w_rd_next   = r_rd_ptr + AW'(1);

  // r_run keeps ready and the ALU pins at zero until the first edge after reset release.
  always_comb begin
    w_ok       = r_run & w_space;
    w_rr_win   = (&bus.i_req_valid) ? r_prio : bus.i_req_valid[1];
    w_rr_grant = w_ok & (|bus.i_req_valid);
`ifdef ALU_ARB_LOCK_EN
    w_win   = r_lock ? r_lock_id : w_rr_win;
    w_grant = r_lock ? (w_ok & bus.i_req_valid[r_lock_id]) : w_rr_grant;
`else
    w_win   = w_rr_win;
    w_grant = w_rr_grant;
`endif
  end

  assign w_push          = w_grant;
  assign bus.o_req_ready = {w_grant & w_win, w_grant & ~w_win};

  always_comb begin
    bus.o_alu_op_a = '0;
    bus.o_alu_op_b = '0;
    bus.o_alu_op   = '0;
    bus.o_alu_jalr = 1'b0;
    if (w_grant) begin
      bus.o_alu_op_a = w_win ? bus.i_req_op_a[63:32]  : bus.i_req_op_a[31:0];
      bus.o_alu_op_b = w_win ? bus.i_req_op_b[63:32]  : bus.i_req_op_b[31:0];
      bus.o_alu_op   = w_win ? bus.i_req_alu_op[7:4] : bus.i_req_alu_op[3:0];
      bus.o_alu_jalr = bus.i_req_jalr[w_win];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_win, bus.i_alu_data};
  end

  // The head lives in its own register so it holds the last popped value once empty.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_head   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_prio   <= PRIO_INIT;
      r_run    <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
`endif
    end else begin
      r_run <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && ((r_count == '0) || (w_pop && r_count == CW'(1))))
        r_head <= {w_win, bus.i_alu_data};
      else if (w_pop && r_count > CW'(1))
        r_head <= r_mem[w_rd_next];
`ifdef ALU_ARB_LOCK_EN
      if (w_push) begin
        r_lock    <= bus.i_req_lock[w_win];
        r_lock_id <= w_win;
        if (!bus.i_req_lock[w_win]) r_prio <= ~w_win;
      end
`else
      if (w_push) r_prio <= ~w_win;
`endif
    end
  end

  assign bus.o_rsp_valid = w_rsp_valid;
  assign bus.o_rsp_id    = r_head[32];
  assign bus.o_rsp_data  = r_head[31:0];
endmodule
